// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller/sequencer.
//  - opcode encodings for the five defined instructions
//  - bit positions of each control line inside the 12-bit control word
//  - CW_NOP: every line in its inactive state
//  - one-hot T-state constants T1..T6
package sap1_pkg;

  localparam int NUM_T    = 6;
  localparam int OPCODE_W = 4;
  localparam int CW_W     = 12;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control word layout, MSB first: CP EP LM' CE' LI' EI' LA' EA SU EU LB' LO'
  localparam int CW_CP   = 11;
  localparam int CW_EP   = 10;
  localparam int CW_LM_N = 9;
  localparam int CW_CE_N = 8;
  localparam int CW_LI_N = 7;
  localparam int CW_EI_N = 6;
  localparam int CW_LA_N = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SU   = 3;
  localparam int CW_EU   = 2;
  localparam int CW_LB_N = 1;
  localparam int CW_LO_N = 0;

  // Active-high lines 0, active-low lines 1.
  localparam logic [CW_W-1:0] CW_NOP = 12'h3E3;

  localparam logic [NUM_T-1:0] T1 = 6'b000001;
  localparam logic [NUM_T-1:0] T2 = 6'b000010;
  localparam logic [NUM_T-1:0] T3 = 6'b000100;
  localparam logic [NUM_T-1:0] T4 = 6'b001000;
  localparam logic [NUM_T-1:0] T5 = 6'b010000;
  localparam logic [NUM_T-1:0] T6 = 6'b100000;

  function automatic logic is_defined_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot ring counter for the SAP-1 T-states.
//  clk    in  rising-edge clock
//  rst    in  synchronous active-high reset -> bit0 (T1)
//  en     in  rotate left by one when high, hold otherwise
//  tstate out one-hot state, bit0=T1 .. bit(NUM_T-1)=last state
module sap1_ring_counter #(
  parameter int NUM_T = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [NUM_T-1:0] tstate
);

  always_ff @(posedge clk) begin
    if (rst)
      tstate <= NUM_T'(1);
    else if (en)
      tstate <= {tstate[NUM_T-2:0], tstate[NUM_T-1]};
  end

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control sequencer: ring counter + opcode decode + sticky halt.
//  clk, rst           clock, synchronous active-high reset
//  step_en            advance enable (free run or single-step pulse)
//  opcode             IR[7:4], only looked at in T4..T6
//  tstate             one-hot T-state (bit0=T1)
//  halt               sticky after HLT executes, cleared by rst only
//  illegal            undefined opcode in T4..T6
//  instr_done         high in T6
//  cp ep ea su eu     active-high control lines
//  lm_n ce_n li_n ei_n la_n lb_n lo_n  active-low control lines
module sap1_controller_sequencer
  import sap1_pkg::*;
#(
  parameter int NUM_T    = 6,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_en,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [NUM_T-1:0]    tstate,
  output logic                halt,
  output logic                illegal,
  output logic                instr_done,
  output logic                cp,
  output logic                ep,
  output logic                ea,
  output logic                su,
  output logic                eu,
  output logic                lm_n,
  output logic                ce_n,
  output logic                li_n,
  output logic                ei_n,
  output logic                la_n,
  output logic                lb_n,
  output logic                lo_n
);

  logic            hlt_now;
  logic            advance;
  logic [CW_W-1:0] cw;
  logic            in_exec;

  // HLT is caught on the T4 edge: set halt and keep the counter parked at T4.
  assign hlt_now = step_en && !halt && (tstate == T4) && (opcode == OP_HLT);
  assign advance = step_en && !halt && !hlt_now;

  sap1_ring_counter #(.NUM_T(NUM_T)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .en     (advance),
    .tstate (tstate)
  );

  always_ff @(posedge clk) begin
    if (rst)
      halt <= 1'b0;
    else if (hlt_now)
      halt <= 1'b1;
  end

  assign in_exec = |tstate[5:3];

  always_comb begin
    cw = CW_NOP;
    if (!rst && !halt) begin
      case (tstate)
        T1: begin cw[CW_EP] = 1'b1; cw[CW_LM_N] = 1'b0; end
        T2: cw[CW_CP] = 1'b1;
        T3: begin cw[CW_CE_N] = 1'b0; cw[CW_LI_N] = 1'b0; end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            cw[CW_EI_N] = 1'b0;
            cw[CW_LM_N] = 1'b0;
          end else if (opcode == OP_OUT) begin
            cw[CW_EA]   = 1'b1;
            cw[CW_LO_N] = 1'b0;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            cw[CW_CE_N] = 1'b0;
            cw[CW_LA_N] = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            cw[CW_CE_N] = 1'b0;
            cw[CW_LB_N] = 1'b0;
            // su raised a state early so the ALU result is settled by T6.
            cw[CW_SU]   = (opcode == OP_SUB);
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            cw[CW_EU]   = 1'b1;
            cw[CW_LA_N] = 1'b0;
            cw[CW_SU]   = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign illegal    = !rst && !halt && in_exec && !is_defined_op(opcode);
  assign instr_done = !rst && !halt && (tstate == T6);

  assign cp   = cw[CW_CP];
  assign ep   = cw[CW_EP];
  assign lm_n = cw[CW_LM_N];
  assign ce_n = cw[CW_CE_N];
  assign li_n = cw[CW_LI_N];
  assign ei_n = cw[CW_EI_N];
  assign la_n = cw[CW_LA_N];
  assign ea   = cw[CW_EA];
  assign su   = cw[CW_SU];
  assign eu   = cw[CW_EU];
  assign lb_n = cw[CW_LB_N];
  assign lo_n = cw[CW_LO_N];

endmodule
